lc3_mc_controller: RTL and testbench

Parametrised multicycle LC-3 control unit, the successor to the fixed-latency controller. It sits between the instruction register/condition codes and the datapath (MARMux, PC, register file, MDR/MAR, ALU, EAB) and drives the same strobes. It adds four things:
- a memory request/ready handshake with configurable timeout;
- the LDR, LDI, STI and LEA opcodes;
- illegal-opcode trapping;
- a retired-instruction counter.

---
 rtl/lc3_mc_controller.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_lc3_mc_controller.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mc_controller.sv
// lc3_mc_controller: multicycle LC-3 control unit with a memory request/ready
// handshake, per-access timeout, illegal-opcode trapping and a retire counter.

package lc3_mc_controller_pkg;
    typedef enum logic [1:0] {
        AluAdd  = 2'b00,
        AluAnd  = 2'b01,
        AluNot  = 2'b10,
        AluPass = 2'b11
    } aluControl_t;
endpackage

module lc3_mc_controller
    import lc3_mc_controller_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT     = 15,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ir,
    input  logic        flagN,
    input  logic        flagZ,
    input  logic        flagP,
    input  logic        memReady,
    output logic        memReq,
    output logic        enaMARM,
    output logic        enaPC,
    output logic        enaMDR,
    output logic        enaALU,
    output logic        ldPC,
    output logic        ldMAR,
    output logic        ldMDR,
    output logic        ldIR,
    output logic        regWE,
    output logic        memWE,
    output logic        flagWE,
    output logic        selMAR,
    output logic        selMDR,
    output logic        selEAB1,
    output logic [1:0]  selPC,
    output logic [1:0]  selEAB2,
    output logic [2:0]  DR,
    output logic [2:0]  SR1,
    output logic [2:0]  SR2,
    output aluControl_t aluControl,
    output logic        instrDone,
    output logic [15:0] retireCount,
    output logic        illegal,
    output logic        fault,
    output logic        halted
);

    localparam int unsigned CntWidth = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CntWidth-1:0] TimeoutVal = CntWidth'(MEM_TIMEOUT);

    localparam logic [3:0] OpBr  = 4'b0000;
    localparam logic [3:0] OpAdd = 4'b0001;
    localparam logic [3:0] OpLd  = 4'b0010;
    localparam logic [3:0] OpSt  = 4'b0011;
    localparam logic [3:0] OpJsr = 4'b0100;
    localparam logic [3:0] OpAnd = 4'b0101;
    localparam logic [3:0] OpLdr = 4'b0110;
    localparam logic [3:0] OpStr = 4'b0111;
    localparam logic [3:0] OpRti = 4'b1000;
    localparam logic [3:0] OpNot = 4'b1001;
    localparam logic [3:0] OpLdi = 4'b1010;
    localparam logic [3:0] OpSti = 4'b1011;
    localparam logic [3:0] OpJmp = 4'b1100;
    localparam logic [3:0] OpRes = 4'b1101;
    localparam logic [3:0] OpLea = 4'b1110;
    localparam logic [3:0] OpTrap = 4'b1111;

    typedef enum logic [4:0] {
        StFetch0, StFetch1, StFetch2, StDecode,
        StAlu, StBr0, StBr1, StJsr0, StJsr1, StJmp, StLea,
        StLd0, StLdr0, StLdi0, StLdi1, StLdi2, StLd1, StLd2,
        StSt0, StStr0, StSti0, StSti1, StSti2, StStA, StStB,
        StHalt, StFault
    } state_t;

    state_t              state_q, state_d;
    logic [CntWidth-1:0] waitCnt_q, waitCnt_d;
    logic [15:0]         retireCount_q, retireCount_d;
    logic                illegal_q, illegal_d;

    logic [3:0] opcode;
    logic       illegalOp;
    logic       brTaken;
    logic       isAccess;
    logic       timeoutHit;
    logic       unusedIr;

    assign opcode    = ir[15:12];
    // Only JSR with the PC-relative form is supported; JSRR traps as illegal.
    assign illegalOp = (opcode == OpRti) || (opcode == OpRes) || (opcode == OpTrap) ||
                       ((opcode == OpJsr) && !ir[11]);
    assign brTaken   = (ir[11] & flagN) | (ir[10] & flagZ) | (ir[9] & flagP);
    assign isAccess  = (state_q == StFetch1) || (state_q == StLd1) || (state_q == StLdi1) ||
                       (state_q == StSti1) || (state_q == StStB);
    // memReady in the final allowed cycle still completes the access.
    assign timeoutHit = isAccess && !memReady && (waitCnt_q == TimeoutVal);
    assign unusedIr   = ^ir[5:3];

    assign retireCount = retireCount_q;
    assign illegal     = illegal_q;
    assign fault       = (state_q == StFault);
    assign halted      = (state_q == StHalt);

    // Next-state logic, including the access hold and timeout override.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch0: state_d = StFetch1;
            StFetch1: state_d = StFetch2;
            StFetch2: state_d = StDecode;
            StDecode: begin
                if (illegalOp) begin
                    state_d = HALT_ON_ILLEGAL ? StHalt : StFetch0;
                end else begin
                    case (opcode)
                        OpAdd, OpAnd, OpNot: state_d = StAlu;
                        OpBr:                state_d = StBr0;
                        OpJsr:               state_d = StJsr0;
                        OpJmp:               state_d = StJmp;
                        OpLea:               state_d = StLea;
                        OpLd:                state_d = StLd0;
                        OpLdr:               state_d = StLdr0;
                        OpLdi:               state_d = StLdi0;
                        OpSt:                state_d = StSt0;
                        OpStr:               state_d = StStr0;
                        OpSti:               state_d = StSti0;
                        default:             state_d = StFetch0;
                    endcase
                end
            end
            StAlu, StBr1, StJsr1, StJmp, StLea, StLd2: state_d = StFetch0;
            StBr0:    state_d = brTaken ? StBr1 : StFetch0;
            StJsr0:   state_d = StJsr1;
            StLd0, StLdr0: state_d = StLd1;
            StLdi0:   state_d = StLdi1;
            StLdi1:   state_d = StLdi2;
            StLdi2:   state_d = StLd1;
            StLd1:    state_d = StLd2;
            StSt0, StStr0: state_d = StStA;
            StSti0:   state_d = StSti1;
            StSti1:   state_d = StSti2;
            StSti2:   state_d = StStA;
            StStA:    state_d = StStB;
            StStB:    state_d = StFetch0;
            StHalt:   state_d = StHalt;
            StFault:  state_d = StFault;
            default:  state_d = StFetch0;
        endcase
        if (isAccess) begin
            if (timeoutHit) begin
                state_d = StFault;
            end else if (!memReady) begin
                state_d = state_q;
            end
        end
    end

    // Wait counter, retire counter and sticky illegal flag next-state.
    always_comb begin
        waitCnt_d     = '0;
        retireCount_d = retireCount_q;
        illegal_d     = illegal_q;
        // Access states are never adjacent, so zero outside them means zero on entry.
        if (isAccess && !memReady) begin
            waitCnt_d = (waitCnt_q == TimeoutVal) ? waitCnt_q : waitCnt_q + CntWidth'(1);
        end
        if (instrDone) begin
            retireCount_d = retireCount_q + 16'd1;
        end
        if ((state_q == StDecode) && illegalOp) begin
            illegal_d = 1'b1;
        end
    end

    // Moore strobes decoded from the current state and ir.
    always_comb begin
        memReq     = 1'b0;
        enaMARM    = 1'b0;
        enaPC      = 1'b0;
        enaMDR     = 1'b0;
        enaALU     = 1'b0;
        ldPC       = 1'b0;
        ldMAR      = 1'b0;
        ldMDR      = 1'b0;
        ldIR       = 1'b0;
        regWE      = 1'b0;
        memWE      = 1'b0;
        flagWE     = 1'b0;
        selMAR     = 1'b0;
        selMDR     = 1'b0;
        selEAB1    = 1'b0;
        selPC      = 2'b00;
        selEAB2    = 2'b00;
        DR         = ir[11:9];
        SR1        = 3'b000;
        SR2        = ir[2:0];
        aluControl = AluPass;
        instrDone  = 1'b0;
        case (state_q)
            StFetch0: begin
                enaPC = 1'b1;
                ldMAR = 1'b1;
            end
            StFetch1: begin
                memReq = 1'b1;
                selMDR = 1'b1;
                ldMDR  = memReady;
                // PC increments once, in the completing cycle only.
                ldPC   = memReady;
                selPC  = 2'b00;
            end
            StFetch2: begin
                enaMDR = 1'b1;
                ldIR   = 1'b1;
            end
            StAlu: begin
                SR1       = ir[8:6];
                regWE     = 1'b1;
                enaALU    = 1'b1;
                flagWE    = 1'b1;
                instrDone = 1'b1;
                case (opcode)
                    OpAdd:   aluControl = AluAdd;
                    OpAnd:   aluControl = AluAnd;
                    OpNot:   aluControl = AluNot;
                    default: aluControl = AluPass;
                endcase
            end
            StBr0: instrDone = !brTaken;
            StBr1: begin
                ldPC      = 1'b1;
                selPC     = 2'b01;
                selEAB2   = 2'b10;
                instrDone = 1'b1;
            end
            StJsr0: begin
                DR    = 3'd7;
                enaPC = 1'b1;
                regWE = 1'b1;
            end
            StJsr1: begin
                ldPC      = 1'b1;
                selPC     = 2'b01;
                selEAB2   = 2'b11;
                instrDone = 1'b1;
            end
            StJmp: begin
                SR1       = ir[8:6];
                ldPC      = 1'b1;
                selPC     = 2'b01;
                selEAB1   = 1'b1;
                selEAB2   = 2'b00;
                instrDone = 1'b1;
            end
            StLea: begin
                enaMARM   = 1'b1;
                selEAB2   = 2'b10;
                regWE     = 1'b1;
                instrDone = 1'b1;
            end
            StLd0, StLdi0, StSt0, StSti0: begin
                enaMARM = 1'b1;
                ldMAR   = 1'b1;
                selEAB2 = 2'b10;
            end
            StLdr0, StStr0: begin
                SR1     = ir[8:6];
                enaMARM = 1'b1;
                ldMAR   = 1'b1;
                selEAB1 = 1'b1;
                selEAB2 = 2'b01;
            end
            StLdi1, StLd1, StSti1: begin
                memReq = 1'b1;
                selMDR = 1'b1;
                ldMDR  = memReady;
            end
            StLdi2, StSti2: begin
                enaMDR = 1'b1;
                ldMAR  = 1'b1;
            end
            StLd2: begin
                enaMDR    = 1'b1;
                regWE     = 1'b1;
                flagWE    = 1'b1;
                instrDone = 1'b1;
            end
            StStA: begin
                SR1    = ir[11:9];
                enaALU = 1'b1;
                ldMDR  = 1'b1;
            end
            StStB: begin
                memReq    = 1'b1;
                memWE     = memReady;
                instrDone = memReady;
            end
            default: ;
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StFetch0;
            waitCnt_q     <= '0;
            retireCount_q <= '0;
            illegal_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            waitCnt_q     <= waitCnt_d;
            retireCount_q <= retireCount_d;
            illegal_q     <= illegal_d;
        end
    end

endmodule

// File: tb/tb_lc3_mc_controller.sv
// Testbench for lc3_mc_controller: table vectors, random instruction stream
// against an instruction-level model, and hand-written multi-cycle corners.

module tb_lc3_mc_controller;
    import lc3_mc_controller_pkg::*;

    typedef struct {
        int          cycles;
        int          regWE;
        int          memWE;
        int          ldPC;
        int          ldMAR;
        int          flagWE;
        logic [3:0]  jumpSel;
        logic [2:0]  dr;
        logic [5:0]  aluSrc;
        aluControl_t alu;
    } obsT;

    typedef struct {
        logic [15:0] instr;
        logic [2:0]  nzp;
        int          stall;
        obsT         exp;
    } vecT;

    logic clk, reset, flagN, flagZ, flagP, memReady;
    logic [15:0] ir;

    logic memReq, enaMARM, enaPC, enaMDR, enaALU, ldPC, ldMAR, ldMDR, ldIR, regWE, memWE;
    logic flagWE, selMAR, selMDR, selEAB1, instrDone, illegal, fault, halted;
    logic [1:0] selPC, selEAB2;
    logic [2:0] DR, SR1, SR2;
    logic [15:0] retireCount;
    aluControl_t aluControl;

    logic bMemReq, bEnaMARM, bEnaPC, bEnaMDR, bEnaALU, bLdPC, bLdMAR, bLdMDR, bLdIR, bRegWE;
    logic bMemWE, bFlagWE, bSelMAR, bSelMDR, bSelEAB1, bInstrDone, bIllegal, bFault, bHalted;
    logic [1:0] bSelPC, bSelEAB2;
    logic [2:0] bDR, bSR1, bSR2;
    logic [15:0] bRetireCount;
    aluControl_t bAluControl;

    logic [19:0] aStrobes, bStrobes;
    assign aStrobes = {memReq, enaMARM, enaPC, enaMDR, enaALU, ldPC, ldMAR, ldMDR, ldIR, regWE,
                       memWE, flagWE, selMAR, selMDR, selEAB1, selPC, selEAB2, instrDone};
    assign bStrobes = {bMemReq, bEnaMARM, bEnaPC, bEnaMDR, bEnaALU, bLdPC, bLdMAR, bLdMDR,
                       bLdIR, bRegWE, bMemWE, bFlagWE, bSelMAR, bSelMDR, bSelEAB1, bSelPC,
                       bSelEAB2, bInstrDone};

    int errors = 0;
    int checks = 0;
    int expRetire;

    lc3_mc_controller #(.MEM_TIMEOUT(4), .HALT_ON_ILLEGAL(1'b1)) dutA (
        .clk(clk), .reset(reset), .ir(ir), .flagN(flagN), .flagZ(flagZ), .flagP(flagP),
        .memReady(memReady), .memReq(memReq), .enaMARM(enaMARM), .enaPC(enaPC),
        .enaMDR(enaMDR), .enaALU(enaALU), .ldPC(ldPC), .ldMAR(ldMAR), .ldMDR(ldMDR),
        .ldIR(ldIR), .regWE(regWE), .memWE(memWE), .flagWE(flagWE), .selMAR(selMAR),
        .selMDR(selMDR), .selEAB1(selEAB1), .selPC(selPC), .selEAB2(selEAB2), .DR(DR),
        .SR1(SR1), .SR2(SR2), .aluControl(aluControl), .instrDone(instrDone),
        .retireCount(retireCount), .illegal(illegal), .fault(fault), .halted(halted)
    );

    lc3_mc_controller #(.MEM_TIMEOUT(15), .HALT_ON_ILLEGAL(1'b0)) dutB (
        .clk(clk), .reset(reset), .ir(ir), .flagN(flagN), .flagZ(flagZ), .flagP(flagP),
        .memReady(memReady), .memReq(bMemReq), .enaMARM(bEnaMARM), .enaPC(bEnaPC),
        .enaMDR(bEnaMDR), .enaALU(bEnaALU), .ldPC(bLdPC), .ldMAR(bLdMAR), .ldMDR(bLdMDR),
        .ldIR(bLdIR), .regWE(bRegWE), .memWE(bMemWE), .flagWE(bFlagWE), .selMAR(bSelMAR),
        .selMDR(bSelMDR), .selEAB1(bSelEAB1), .selPC(bSelPC), .selEAB2(bSelEAB2), .DR(bDR),
        .SR1(bSR1), .SR2(bSR2), .aluControl(bAluControl), .instrDone(bInstrDone),
        .retireCount(bRetireCount), .illegal(bIllegal), .fault(bFault), .halted(bHalted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic obsT mkObs(int cycles, int rwe, int mwe, int lpc, int lmar, int fwe,
                                  logic [3:0] js, logic [2:0] dr, logic [5:0] src,
                                  aluControl_t alu);
        obsT o;
        o.cycles = cycles; o.regWE = rwe; o.memWE = mwe; o.ldPC = lpc; o.ldMAR = lmar;
        o.flagWE = fwe; o.jumpSel = js; o.dr = dr; o.aluSrc = src; o.alu = alu;
        return o;
    endfunction

    // Instruction-level model: cycle cost and strobe pulse counts per opcode.
    function automatic obsT model(logic [15:0] instr, logic [2:0] nzp, int s0, int s1, int s2);
        obsT e;
        logic [3:0] op;
        op = instr[15:12];
        e = mkObs(5 + s0, 0, 0, 1, 1, 0, 4'b0000, 3'd0, 6'd0, AluPass);
        case (op)
            4'd1, 4'd5, 4'd9: begin
                e.regWE = 1; e.flagWE = 1; e.dr = instr[11:9];
                e.aluSrc = {instr[8:6], instr[2:0]};
                e.alu = (op == 4'd1) ? AluAdd : (op == 4'd5) ? AluAnd : AluNot;
            end
            4'd0: if ((instr[11:9] & nzp) != 3'b000) begin
                e.cycles += 1; e.ldPC = 2; e.jumpSel = 4'b0110;
            end
            4'd4: begin e.cycles += 1; e.regWE = 1; e.dr = 3'd7; e.ldPC = 2; e.jumpSel = 4'b0111; end
            4'd12: begin e.ldPC = 2; e.jumpSel = 4'b0100; end
            4'd14: begin e.regWE = 1; e.dr = instr[11:9]; end
            4'd2, 4'd6: begin
                e.cycles += 2 + s1; e.regWE = 1; e.flagWE = 1; e.dr = instr[11:9]; e.ldMAR = 2;
            end
            4'd10: begin
                e.cycles += 4 + s1 + s2; e.regWE = 1; e.flagWE = 1; e.dr = instr[11:9];
                e.ldMAR = 3;
            end
            4'd3, 4'd7: begin e.cycles += 2 + s1; e.memWE = 1; e.ldMAR = 2; end
            4'd11: begin e.cycles += 4 + s1 + s2; e.memWE = 1; e.ldMAR = 3; end
            default: ;
        endcase
        return e;
    endfunction

    // Called at a falling edge with the DUT in FETCH0; returns at a falling edge.
    task automatic runInstr(input logic [15:0] instr, input logic [2:0] nzp,
                            input int s0, input int s1, input int s2,
                            output obsT got, output bit ok);
        int stalls[3];
        int acc;
        int waitN;
        bit done;
        bit stop;
        obsT g;
        stalls[0] = s0; stalls[1] = s1; stalls[2] = s2;
        acc = 0; waitN = 0; ok = 1'b0;
        g = mkObs(0, 0, 0, 0, 0, 0, 4'b0000, 3'd0, 6'd0, AluPass);
        ir = instr;
        {flagN, flagZ, flagP} = nzp;
        for (int c = 0; c < 200; c++) begin
            if (memReq) memReady = (waitN >= ((acc < 3) ? stalls[acc] : 0));
            else memReady = 1'($urandom_range(0, 1));
            #1;
            g.cycles++;
            if (regWE) begin g.regWE++; g.dr = DR; end
            if (memWE) g.memWE++;
            if (ldPC) begin
                g.ldPC++;
                if (!memReq) g.jumpSel = {selPC, selEAB2};
            end
            if (ldMAR) g.ldMAR++;
            if (flagWE) g.flagWE++;
            if (enaALU) g.alu = aluControl;
            if (enaALU && regWE) g.aluSrc = {SR1, SR2};
            if (memReq) begin
                if (memReady) begin acc++; waitN = 0; end
                else waitN++;
            end
            done = instrDone;
            stop = halted | fault;
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
            if (stop) break;
        end
        got = g;
    endtask

    task automatic cmpObs(input string tag, input obsT g, input obsT e);
        chk({tag, " cycles"}, g.cycles, e.cycles);
        chk({tag, " regWE"}, g.regWE, e.regWE);
        chk({tag, " memWE"}, g.memWE, e.memWE);
        chk({tag, " ldPC"}, g.ldPC, e.ldPC);
        chk({tag, " ldMAR"}, g.ldMAR, e.ldMAR);
        chk({tag, " flagWE"}, g.flagWE, e.flagWE);
        chk({tag, " jumpSel"}, int'(g.jumpSel), int'(e.jumpSel));
        chk({tag, " DR"}, int'(g.dr), int'(e.dr));
        chk({tag, " aluSrc"}, int'(g.aluSrc), int'(e.aluSrc));
        chk({tag, " aluControl"}, int'(g.alu), int'(e.alu));
    endtask

    task automatic doReset();
        reset = 1'b1;
        memReady = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vecT tbl[16];
        obsT got;
        bit ok;
        int cnt0, cnt1, cnt2;
        logic [3:0] ops[13];
        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12,
                4'd14};

        tbl[0]  = '{16'h1261, 3'b000, 0, mkObs(5, 1, 0, 1, 1, 1, 4'h0, 3'd1, 6'o11, AluAdd)};
        tbl[1]  = '{16'h1261, 3'b000, 0, mkObs(5, 1, 0, 1, 1, 1, 4'h0, 3'd1, 6'o11, AluAdd)};
        tbl[2]  = '{16'h1261, 3'b000, 0, mkObs(5, 1, 0, 1, 1, 1, 4'h0, 3'd1, 6'o11, AluAdd)};
        tbl[3]  = '{16'hA402, 3'b000, 3, mkObs(18, 1, 0, 1, 3, 1, 4'h0, 3'd2, 6'o00, AluPass)};
        tbl[4]  = '{16'h0405, 3'b010, 0, mkObs(6, 0, 0, 2, 1, 0, 4'h6, 3'd0, 6'o00, AluPass)};
        tbl[5]  = '{16'h0405, 3'b100, 0, mkObs(5, 0, 0, 1, 1, 0, 4'h0, 3'd0, 6'o00, AluPass)};
        tbl[6]  = '{16'h3600, 3'b000, 0, mkObs(7, 0, 1, 1, 2, 0, 4'h0, 3'd0, 6'o00, AluPass)};
        tbl[7]  = '{16'hB200, 3'b000, 1, mkObs(12, 0, 1, 1, 3, 0, 4'h0, 3'd0, 6'o00, AluPass)};
        tbl[8]  = '{16'h2A00, 3'b000, 2, mkObs(11, 1, 0, 1, 2, 1, 4'h0, 3'd5, 6'o00, AluPass)};
        tbl[9]  = '{16'hC1C0, 3'b000, 0, mkObs(5, 0, 0, 2, 1, 0, 4'h4, 3'd0, 6'o00, AluPass)};
        tbl[10] = '{16'h4800, 3'b000, 1, mkObs(7, 1, 0, 2, 1, 0, 4'h7, 3'd7, 6'o00, AluPass)};
        tbl[11] = '{16'hEE00, 3'b000, 0, mkObs(5, 1, 0, 1, 1, 0, 4'h0, 3'd7, 6'o00, AluPass)};
        tbl[12] = '{16'h7000, 3'b000, 0, mkObs(7, 0, 1, 1, 2, 0, 4'h0, 3'd0, 6'o00, AluPass)};
        tbl[13] = '{16'h6C00, 3'b000, 1, mkObs(9, 1, 0, 1, 2, 1, 4'h0, 3'd6, 6'o00, AluPass)};
        // Four not-ready cycles: completion in the last allowed cycle, no fault.
        tbl[14] = '{16'h923F, 3'b000, 4, mkObs(9, 1, 0, 1, 1, 1, 4'h0, 3'd1, 6'o07, AluNot)};
        tbl[15] = '{16'h5A21, 3'b000, 0, mkObs(5, 1, 0, 1, 1, 1, 4'h0, 3'd5, 6'o01, AluAnd)};

        reset = 1'b1; ir = 16'h0000; flagN = 1'b0; flagZ = 1'b0; flagP = 1'b0;
        memReady = 1'b0;
        doReset();
        #1;
        chk("reset memReq", int'(memReq), 0);
        chk("reset instrDone", int'(instrDone), 0);
        chk("reset retireCount", int'(retireCount), 0);
        chk("reset status", int'({illegal, fault, halted}), 0);
        chk("reset FETCH0 enaPC", int'(enaPC), 1);
        chk("reset FETCH0 ldMAR", int'(ldMAR), 1);

        expRetire = 0;
        for (int i = 0; i < 16; i++) begin
            runInstr(tbl[i].instr, tbl[i].nzp, tbl[i].stall, tbl[i].stall, tbl[i].stall, got, ok);
            chk($sformatf("vec%0d completes", i), int'(ok), 1);
            cmpObs($sformatf("vec%0d", i), got, tbl[i].exp);
            expRetire++;
            chk($sformatf("vec%0d retireCount", i), int'(retireCount), expRetire);
        end
        chk("table no fault", int'(fault), 0);

        // Timeout: memReady never arrives during the fetch read.
        doReset();
        ir = 16'h1261;
        cnt0 = 0; cnt1 = 0;
        for (int c = 0; c < 30; c++) begin
            memReady = 1'b0;
            #1;
            if (fault) break;
            cnt0 += int'(memReq);
            cnt1 += int'(ldPC);
            @(negedge clk);
        end
        chk("timeout fault", int'(fault), 1);
        chk("timeout wait cycles", cnt0, 5);
        chk("timeout ldPC", cnt1, 0);
        chk("timeout retireCount", int'(retireCount), 0);
        chk("fault strobes", int'(aStrobes), 0);

        // Illegal opcode 0xD000: halt on A, skip on B.
        doReset();
        ir = 16'hD000;
        for (int c = 0; c < 4; c++) begin
            memReady = 1'b1;
            @(negedge clk);
        end
        #1;
        chk("illegal halted", int'(halted), 1);
        chk("illegal flag", int'(illegal), 1);
        chk("halt strobes", int'(aStrobes), 0);
        chk("skip illegal flag", int'(bIllegal), 1);
        chk("skip not halted", int'({bHalted, bFault}), 0);
        chk("skip FETCH0 strobes", int'(bStrobes), 32'h22000);
        chk("skip regaddr defaults", int'({bDR, bSR1, bSR2}), 0);
        chk("skip aluControl", int'(bAluControl), int'(AluPass));
        ir = 16'h1261;
        cnt0 = 0; cnt1 = 0;
        for (int c = 0; c < 5; c++) begin
            memReady = 1'b1;
            #1;
            cnt0 += int'(bInstrDone);
            if (aStrobes != 20'd0 || !halted) cnt1++;
            @(negedge clk);
        end
        chk("skip then ADD instrDone", cnt0, 1);
        chk("skip then ADD retireCount", int'(bRetireCount), 1);
        chk("halt stays quiet", cnt1, 0);
        chk("halt retireCount", int'(retireCount), 0);

        // Reset while STI1 has been waiting two cycles.
        doReset();
        ir = 16'hB000;
        cnt0 = 0; cnt1 = 0;
        for (int c = 0; c < 5; c++) begin
            memReady = 1'b1;
            #1;
            cnt1 += int'(memWE);
            @(negedge clk);
        end
        for (int c = 0; c < 2; c++) begin
            memReady = 1'b0;
            #1;
            cnt0 += int'(memReq);
            cnt1 += int'(memWE);
            @(negedge clk);
        end
        reset = 1'b1;
        memReady = 1'b0;
        @(negedge clk);
        #1;
        chk("STI1 wait cycles", cnt0, 2);
        chk("midreset memReq", int'(memReq), 0);
        chk("midreset FETCH0", int'(enaPC & ldMAR), 1);
        chk("midreset memWE never", cnt1 + int'(memWE), 0);
        chk("midreset status", int'({illegal, fault, halted}), 0);
        chk("midreset retireCount", int'(retireCount), 0);
        reset = 1'b0;

        // Random legal instruction stream with random stalls.
        expRetire = 0;
        for (int i = 0; i < 40; i++) begin
            logic [15:0] instr;
            logic [2:0] nzp;
            logic [3:0] op;
            op = ops[$urandom_range(0, 12)];
            instr = {op, 12'($urandom)};
            if (op == 4'd4) instr[11] = 1'b1;
            nzp = 3'($urandom);
            cnt0 = $urandom_range(0, 3);
            cnt1 = $urandom_range(0, 3);
            cnt2 = $urandom_range(0, 3);
            runInstr(instr, nzp, cnt0, cnt1, cnt2, got, ok);
            chk($sformatf("rand%0d %h completes", i, instr), int'(ok), 1);
            cmpObs($sformatf("rand%0d %h", i, instr), got, model(instr, nzp, cnt0, cnt1, cnt2));
            expRetire++;
            chk($sformatf("rand%0d retireCount", i), int'(retireCount), expRetire);
        end
        chk("random no fault", int'({fault, halted, illegal}), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
